// File: rtl/afe_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : afe_spi_master
// Purpose  : Serial configuration master for the AFE control port. Runs the
//            AFE power-up reset sequence after reset_n is released, then
//            executes single register read/write frames (mode 0, MSB first)
//            requested over a valid/ready command interface. Each frame
//            returns one response carrying the last DATA_WIDTH MISO bits.
// Ports    : clk, reset_n           - system clock, async active-low reset
//            cmd_valid/cmd_ready    - command handshake
//            cmd_rw/addr/wdata      - command fields, captured on accept
//            rsp_valid/rsp_rdata    - one-cycle response pulse and read data
//            busy                   - frame in progress (accept to ready)
//            spi_clk/mosi/miso/sen  - serial port to the AFE
//            afe_rst                - active-high AFE reset
// Revision : 1.0 - initial release
// ============================================================================
module afe_spi_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_sen,
  output logic                  afe_rst
);

  localparam int c_FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int c_MAX_A      = (RST_CYCLES > CLK_DIV) ? RST_CYCLES : CLK_DIV;
  localparam int c_CNT_MAX    = (c_MAX_A > c_FRAME_BITS) ? c_MAX_A : c_FRAME_BITS;
  localparam int c_CNT_W      = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(c_FRAME_BITS - 1);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RST_WAIT = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    SHIFT_HI = 3'd4,
    SHIFT_LO = 3'd5,
    GAP      = 3'd6
  } state_t;

  state_t                  r_state;
  logic [c_CNT_W-1:0]      r_cnt;        // cycles spent in the current state
  logic [c_CNT_W-1:0]      r_bit;        // index of the bit being shifted
  logic [c_FRAME_BITS-1:0] r_shift;      // outgoing word, current bit at MSB
  logic [DATA_WIDTH-1:0]   r_rx;         // incoming bits, newest at LSB
  logic                    r_miso_meta;
  logic                    r_miso_sync;

  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_busy;
  logic                    r_spi_clk;
  logic                    r_spi_mosi;
  logic                    r_spi_sen;
  logic                    r_afe_rst;

  logic                    w_div_done;
  logic [DATA_WIDTH-1:0]   w_data_field;

  assign w_div_done   = (r_cnt == c_DIV_LAST);
  // Reads clock out zeros in the data phase so the AFE sees a clean frame.
  assign w_data_field = cmd_rw ? '0 : cmd_wdata;

  // Two-flop synchroniser for the asynchronous MISO line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_miso_meta <= spi_miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RST_HOLD;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_spi_clk   <= 1'b0;
      r_spi_mosi  <= 1'b0;
      r_spi_sen   <= 1'b1;
      r_afe_rst   <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        RST_HOLD: begin
          if (r_cnt == c_RST_LAST) begin
            r_cnt     <= '0;
            r_afe_rst <= 1'b0;
            r_state   <= RST_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RST_WAIT: begin
          if (r_cnt == c_RST_LAST) begin
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // cmd_ready is always high in this state, so cmd_valid alone
        // marks the accepting edge.
        IDLE: begin
          if (cmd_valid) begin
            r_shift     <= {cmd_rw, cmd_addr, w_data_field};
            r_spi_mosi  <= cmd_rw;
            r_spi_sen   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_state     <= SETUP;
          end
        end

        SETUP: begin
          if (w_div_done) begin
            r_cnt     <= '0;
            r_spi_clk <= 1'b1;
            r_state   <= SHIFT_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          // Capture once per bit, at the first high cycle; the AFE updated
          // MISO at the previous falling edge, which is at least CLK_DIV
          // cycles earlier than this sample.
          if (r_cnt == '0) begin
            r_rx <= {r_rx[DATA_WIDTH-2:0], r_miso_sync};
          end
          if (w_div_done) begin
            r_cnt     <= '0;
            r_spi_clk <= 1'b0;
            r_shift   <= r_shift << 1;
            r_spi_mosi <= (r_bit == c_BIT_LAST) ? 1'b0 : r_shift[c_FRAME_BITS-2];
            r_state   <= SHIFT_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        SHIFT_LO: begin
          if (w_div_done) begin
            r_cnt <= '0;
            if (r_bit == c_BIT_LAST) begin
              r_spi_sen   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_rx;
              r_state     <= GAP;
            end else begin
              r_bit     <= r_bit + 1'b1;
              r_spi_clk <= 1'b1;
              r_state   <= SHIFT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        GAP: begin
          if (w_div_done) begin
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= RST_HOLD;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;
  assign spi_clk   = r_spi_clk;
  assign spi_mosi  = r_spi_mosi;
  assign spi_sen   = r_spi_sen;
  assign afe_rst   = r_afe_rst;

endmodule
`default_nettype wire

// File: tb/tb_afe_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_afe_spi_master
// Purpose  : Self-checking bench for afe_spi_master. Drives directed and
//            random register frames, models the AFE serial port, and checks
//            framing, timing, reset sequencing and response data against
//            values derived from the frame format and timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afe_spi_master;

  localparam int AW      = 15;
  localparam int DW      = 8;
  localparam int DIV     = 4;
  localparam int RSTC    = 64;
  localparam int F       = 1 + AW + DW;
  localparam int SEN_LOW = DIV * (1 + 2 * F);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-parameter instance ----------------
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          spi_clk;
  logic          spi_mosi;
  logic          spi_miso = 1'b0;
  logic          spi_sen;
  logic          afe_rst;

  afe_spi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(DIV), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_sen(spi_sen), .afe_rst(afe_rst)
  );

  // ---------------- CLK_DIV=1 instance (write-only use) ----------------
  logic          rst1_n;
  logic          valid1;
  logic          ready1;
  logic          rw1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic          rspv1;
  logic [DW-1:0] rdata1;
  logic          busy1;
  logic          sclk1;
  logic          mosi1;
  logic          miso1 = 1'b0;
  logic          sen1;
  logic          afer1;

  afe_spi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(1), .RST_CYCLES(RSTC)) dut1 (
    .clk(clk), .reset_n(rst1_n),
    .cmd_valid(valid1), .cmd_ready(ready1), .cmd_rw(rw1),
    .cmd_addr(addr1), .cmd_wdata(wd1),
    .rsp_valid(rspv1), .rsp_rdata(rdata1), .busy(busy1),
    .spi_clk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1),
    .spi_sen(sen1), .afe_rst(afer1)
  );

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MOSI as seen by the AFE: sampled on each SCLK rising edge.
  logic [F-1:0] mon_bits = '0;
  int           mon_n    = 0;
  always @(posedge spi_clk) begin
    mon_bits = {mon_bits[F-2:0], spi_mosi};
    mon_n++;
  end

  logic [F-1:0] mon1_bits = '0;
  int           mon1_n    = 0;
  always @(posedge sclk1) begin
    mon1_bits = {mon1_bits[F-2:0], mosi1};
    mon1_n++;
  end

  // AFE model: first bit presented when SEN falls, next bit after each
  // SCLK falling edge (mode 0).
  logic [F-1:0] afe_word   = '0;
  int           afe_idx    = 0;
  bit           afe_active = 1'b0;
  always @(negedge spi_sen or posedge spi_sen or negedge spi_clk) begin
    if (spi_sen) begin
      afe_active = 1'b0;
    end else if (!afe_active) begin
      afe_active = 1'b1;
      afe_idx    = F - 1;
    end else if (afe_idx > 0) begin
      afe_idx--;
    end
    spi_miso = afe_word[afe_idx];
  end

  // Frame and response counters, sampled away from the active edge.
  int n_rsp      = 0;
  int n_sen_fall = 0;
  logic sen_d    = 1'b1;
  always @(negedge clk) begin
    if (rsp_valid) n_rsp++;
    if (sen_d && !spi_sen) n_sen_fall++;
    sen_d = spi_sen;
  end

  // ---------------- tasks ----------------
  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({pfx, "_busy"},      32'(busy),      32'd0);
    check({pfx, "_spi_clk"},   32'(spi_clk),   32'd0);
    check({pfx, "_spi_mosi"},  32'(spi_mosi),  32'd0);
    check({pfx, "_spi_sen"},   32'(spi_sen),   32'd1);
    check({pfx, "_afe_rst"},   32'(afe_rst),   32'd1);
  endtask

  // Caller is at a falling clock edge with reset_n low.
  task automatic power_up_check(input string pfx);
    int rst_fall  = -1;
    int rdy_rise  = -1;
    int sen_lo    = 0;
    int rst_again = 0;
    reset_n = 1'b1;
    for (int k = 0; k <= 2 * RSTC + 2; k++) begin
      if (!afe_rst && rst_fall < 0) rst_fall = k;
      if (afe_rst && rst_fall >= 0) rst_again++;
      if (cmd_ready && rdy_rise < 0) rdy_rise = k;
      if (!spi_sen) sen_lo++;
      @(negedge clk);
    end
    check({pfx, "_afe_rst_fall"}, 32'(rst_fall),  32'(RSTC));
    check({pfx, "_afe_rst_again"}, 32'(rst_again), 32'd0);
    check({pfx, "_ready_rise"},   32'(rdy_rise),  32'(2 * RSTC));
    check({pfx, "_sen_low"},      32'(sen_lo),    32'd0);
  endtask

  // One frame, starting at a falling clock edge. With hold set, cmd_valid is
  // left high so the next call is picked up back-to-back. Returns the count
  // of SEN-high cycles before the frame and after it up to cmd_ready.
  task automatic run_frame(input logic rw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [F-1:0] miso_w,
                           input bit hold, output int hi_head, output int hi_tail);
    int guard     = 0;
    int k         = 1;
    int sen_first = -1;
    int sen_last  = -1;
    int sen_cnt   = 0;
    int rsp_cnt   = 0;
    int rsp_at    = -1;
    int busy_cnt  = 0;
    int ready_at  = -1;
    bit done      = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [F-1:0]  exp_word;
    exp_word  = {rw, addr, (rw ? {DW{1'b0}} : wd)};
    afe_word  = miso_w;
    mon_n     = 0;
    mon_bits  = '0;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 2000), 32'd1);
    @(negedge clk);  // accepted on the rising edge just passed; now cycle 1
    if (!hold) cmd_valid = 1'b0;
    // Post-accept changes must not reach the frame.
    cmd_rw    = ~rw;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    while (!done && k <= SEN_LOW + DIV + 50) begin
      if (!spi_sen) begin
        sen_cnt++;
        if (sen_first < 0) sen_first = k;
        sen_last = k;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_at = k;
        rdata  = rsp_rdata;
      end
      if (cmd_ready) begin
        ready_at = k;
        done     = 1'b1;
        check("busy_at_ready", 32'(busy), 32'd0);
      end else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        k++;
      end
    end
    check("sen_first",  32'(sen_first), 32'd1);
    check("sen_count",  32'(sen_cnt),   32'(SEN_LOW));
    check("sen_last",   32'(sen_last),  32'(SEN_LOW));
    check("rsp_count",  32'(rsp_cnt),   32'd1);
    check("rsp_cycle",  32'(rsp_at),    32'(SEN_LOW + 1));
    check("rsp_rdata",  32'(rdata),     32'(miso_w[DW-1:0]));
    check("ready_cycle", 32'(ready_at), 32'(SEN_LOW + 1 + DIV));
    check("busy_cycles", 32'(busy_cnt), 32'(SEN_LOW + DIV));
    check("sclk_edges", 32'(mon_n),     32'(F));
    check("mosi_word",  32'(mon_bits),  32'(exp_word));
    check("rdata_hold", 32'(rsp_rdata), 32'(miso_w[DW-1:0]));
    hi_head = sen_first - 1;
    hi_tail = ready_at - sen_last;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int h0, t0, h1, t1, h2, t2;
    int base_sen, base_rsp, guard;
    int k1, sen_lo1, sclk_hi1, rsp_at1, ready_at1;
    bit done1;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rst1_n    = 1'b0;
    valid1    = 1'b0;
    rw1       = 1'b0;
    addr1     = '0;
    wd1       = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    power_up_check("pwr");

    // Directed write and read.
    run_frame(1'b0, 15'h0025, 8'hA5, 24'h5A5AC3, 1'b0, h0, t0);
    run_frame(1'b1, 15'h0001, 8'hFF, {16'($urandom), 8'h3C}, 1'b0, h0, t0);

    // Random frames.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_frame(1'($urandom), AW'($urandom), DW'($urandom), F'($urandom), 1'b0, h0, t0);
    end

    // Three queued commands with cmd_valid held high throughout.
    repeat (4) @(negedge clk);
    base_sen = n_sen_fall;
    base_rsp = n_rsp;
    run_frame(1'b0, AW'($urandom), DW'($urandom), F'($urandom), 1'b1, h0, t0);
    run_frame(1'b1, AW'($urandom), DW'($urandom), F'($urandom), 1'b1, h1, t1);
    run_frame(1'b0, AW'($urandom), DW'($urandom), F'($urandom), 1'b0, h2, t2);
    repeat (300) @(negedge clk);
    check("queue_frames", 32'(n_sen_fall - base_sen), 32'd3);
    check("queue_rsps",   32'(n_rsp - base_rsp),      32'd3);
    check("queue_gap01",  32'(t0 + h1 >= DIV + 1),    32'd1);
    check("queue_gap12",  32'(t1 + h2 >= DIV + 1),    32'd1);

    // Reset mid-frame at SCLK bit 10 of a write.
    afe_word  = F'($urandom);
    mon_n     = 0;
    cmd_rw    = 1'b0;
    cmd_addr  = 15'h1234;
    cmd_wdata = 8'h5C;
    cmd_valid = 1'b1;
    guard     = 0;
    while (mon_n < 10 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (busy) cmd_valid = 1'b0;
    end
    check("abort_reach_bit10", 32'(guard < 2000), 32'd1);
    cmd_valid = 1'b0;
    base_rsp  = n_rsp;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    check("abort_no_rsp_in_reset", 32'(n_rsp - base_rsp), 32'd0);
    power_up_check("repwr");
    check("abort_no_rsp_after", 32'(n_rsp - base_rsp), 32'd0);
    run_frame(1'b0, 15'h7ABC, 8'h81, F'($urandom), 1'b0, h0, t0);

    // CLK_DIV=1 instance: write 0x7FFFFF.
    rst1_n = 1'b1;
    guard  = 0;
    while (!ready1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("div1_ready_wait", 32'(guard), 32'(2 * RSTC));
    mon1_n    = 0;
    rw1       = 1'b0;
    addr1     = 15'h7FFF;
    wd1       = 8'hFF;
    valid1    = 1'b1;
    @(negedge clk);
    valid1    = 1'b0;
    addr1     = '0;
    wd1       = '0;
    k1        = 1;
    sen_lo1   = 0;
    sclk_hi1  = 0;
    rsp_at1   = -1;
    ready_at1 = -1;
    done1     = 1'b0;
    while (!done1 && k1 <= 200) begin
      if (!sen1) sen_lo1++;
      if (sclk1) sclk_hi1++;
      if (rspv1) rsp_at1 = k1;
      if (ready1) begin
        ready_at1 = k1;
        done1     = 1'b1;
      end else begin
        @(negedge clk);
        k1++;
      end
    end
    check("div1_sen_low",   32'(sen_lo1),   32'(1 + 2 * F));
    check("div1_sclk_high", 32'(sclk_hi1),  32'(F));
    check("div1_sclk_rise", 32'(mon1_n),    32'(F));
    check("div1_mosi_word", 32'(mon1_bits), 32'h7FFFFF);
    check("div1_rsp_cycle", 32'(rsp_at1),   32'(2 + 2 * F));
    check("div1_ready",     32'(ready_at1), 32'(3 + 2 * F));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
